pipelined_slice_adder: RTL and testbench

//   Parametrised successor of the single-bit full adder: a WIDTH-bit adder with carry-in,

---
 rtl/pipelined_slice_adder.sv | 133 +++++++++++++
 tb/tb_pipelined_slice_adder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_slice_adder.sv
// pipelined_slice_adder: WIDTH-bit adder with carry-in, cut into STAGES
// carry-propagating slices with one register boundary per slice.
// valid/ready streaming on both sides, global stall on back-pressure.
// Optional feature macro: PIPE_ADDER_SAT_EN (signed saturation of out_sum
// in the final stage; out_carry/out_ovf keep reporting the raw flags).
module pipelined_slice_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int SW = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_slice_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  // Per-stage registers: valid bit, skewed operands, partial sum, slice carry
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             cy_q  [STAGES];
  logic             ovf_q;

  // Per-stage combinational view: what enters the stage and what it produces
  logic             vin_w  [STAGES];
  logic [WIDTH-1:0] a_w    [STAGES];
  logic [WIDTH-1:0] b_w    [STAGES];
  logic [WIDTH-1:0] sum_w  [STAGES];
  logic             cin_w  [STAGES];
  logic [WIDTH-1:0] sum_nx [STAGES];
  logic             cy_nx  [STAGES];

  logic             advance;
  logic             carry_into_msb;
  logic             ovf_nx;
  logic [WIDTH-1:0] sum_fin;

  assign advance  = !vld_q[STAGES-1] || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW:0]      slice;
    logic [WIDTH-1:0] merged;

    if (k == 0) begin : g_head
      assign vin_w[k] = in_valid;
      assign a_w[k]   = in_a;
      assign b_w[k]   = in_b;
      assign cin_w[k] = in_carry;
      assign sum_w[k] = '0;
    end else begin : g_tail
      assign vin_w[k] = vld_q[k-1];
      assign a_w[k]   = a_q[k-1];
      assign b_w[k]   = b_q[k-1];
      assign cin_w[k] = cy_q[k-1];
      assign sum_w[k] = sum_q[k-1];
    end

    assign slice = {1'b0, a_w[k][k*SW +: SW]} + {1'b0, b_w[k][k*SW +: SW]}
                 + {{SW{1'b0}}, cin_w[k]};

    // Drop this stage's slice result into the sum carried forward from earlier stages
    always_comb begin
      merged = sum_w[k];
      merged[k*SW +: SW] = slice[SW-1:0];
    end

    assign sum_nx[k] = merged;
    assign cy_nx[k]  = slice[SW];
  end

  // Signed overflow: carry into the MSB recovered from the MSB sum bit and operands
  assign carry_into_msb = a_w[STAGES-1][WIDTH-1] ^ b_w[STAGES-1][WIDTH-1]
                        ^ sum_nx[STAGES-1][WIDTH-1];
  assign ovf_nx = carry_into_msb ^ cy_nx[STAGES-1];

`ifdef PIPE_ADDER_SAT_EN
  // Clamp to the most positive/negative value; sign of the operands tells direction
  always_comb begin
    sum_fin = sum_nx[STAGES-1];
    if (ovf_nx)
      sum_fin = {a_w[STAGES-1][WIDTH-1], {(WIDTH-1){~a_w[STAGES-1][WIDTH-1]}}};
  end
`else
  assign sum_fin = sum_nx[STAGES-1];
`endif

  // Whole pipe shifts together on advance; data only loads behind a valid beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        cy_q[k]  <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vin_w[k];
        if (vin_w[k]) begin
          a_q[k]   <= a_w[k];
          b_q[k]   <= b_w[k];
          cy_q[k]  <= cy_nx[k];
          sum_q[k] <= (k == STAGES - 1) ? sum_fin : sum_nx[k];
        end
      end
      if (vin_w[STAGES-1])
        ovf_q <= ovf_nx;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_carry = cy_q[STAGES-1];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_slice_adder.sv
// Testbench for pipelined_slice_adder (WIDTH=16, STAGES=4), directed vectors
// with hand-computed results plus a short random stream; a negedge monitor
// scores every emitted beat against an expected-result queue.
module tb_pipelined_slice_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_carry;
  logic        out_ovf;

  pipelined_slice_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  // Hand-computed directed vectors
  localparam logic [15:0] VA [10] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h00FF,
                                      16'h0FFF, 16'hFFFF, 16'h1111, 16'h8000, 16'h7FFF};
  localparam logic [15:0] VB [10] = '{16'h0FFF, 16'h0000, 16'h0001, 16'h8000, 16'h0001,
                                      16'h0001, 16'hFFFF, 16'h2222, 16'hFFFF, 16'h7FFF};
  localparam logic        VC [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
`ifdef PIPE_ADDER_SAT_EN
  localparam logic [15:0] VS [10] = '{16'h2233, 16'h0000, 16'h7FFF, 16'h8000, 16'h0100,
                                      16'h1000, 16'hFFFF, 16'h3334, 16'h8000, 16'h7FFF};
`else
  localparam logic [15:0] VS [10] = '{16'h2233, 16'h0000, 16'h8000, 16'h0000, 16'h0100,
                                      16'h1000, 16'hFFFF, 16'h3334, 16'h7FFF, 16'hFFFF};
`endif
  localparam logic        VK [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic        VO [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   stall_lo = -1;
  int   stall_hi = -1;
  exp_t cur_exp;
  exp_t exp_q [$];
  bit   prev_stall = 0;
  logic [15:0] prev_sum;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed === expected)
      n_pass++;
    else
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Independent reference: carry into MSB xor carry out gives signed overflow
  function automatic exp_t refModel(input logic [15:0] a, input logic [15:0] b, input logic cin);
    exp_t        e;
    logic [16:0] full;
    logic        cmsb;
    full    = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    cmsb    = a[15] ^ b[15] ^ full[15];
    e.sum   = full[15:0];
    e.carry = full[16];
    e.ovf   = cmsb ^ full[16];
`ifdef PIPE_ADDER_SAT_EN
    if (e.ovf) e.sum = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return e;
  endfunction

  function automatic exp_t vecExp(input int i);
    exp_t e;
    e.sum   = VS[i];
    e.carry = VK[i];
    e.ovf   = VO[i];
    return e;
  endfunction

  // Drive one beat (or a bubble) and hold it until the DUT accepts it
  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input exp_t e, output int tries);
    bit acc;
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_carry = cin;
    cur_exp  = e;
    tries    = 0;
    forever begin
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      out_ready = !(cyc >= stall_lo && cyc < stall_hi);
      tries++;
      if (acc || !v) break;
      if (tries >= 40) begin
        checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic sendVec(input int i);
    int t;
    applyStimulus(1'b1, VA[i], VB[i], VC[i], vecExp(i), t);
  endtask

  task automatic idle(input int n);
    int t;
    exp_t z;
    z = '0;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, z, t);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      idle(1);
      guard++;
    end
    checkOutput(tag, exp_q.size(), 32'd0);
  endtask

  task automatic measureLatency(input int i, input string tag);
    int lat;
    sendVec(i);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput(tag, lat, STAGES);
  endtask

  // Scoreboard monitor: scores emitted beats, checks stall behaviour, logs accepts
  always @(negedge clk) begin
    exp_t e;
    if (rst_n !== 1'b1) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_beat", {31'b0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sum", {16'b0, out_sum}, {16'b0, e.sum});
          checkOutput("carry", {31'b0, out_carry}, {31'b0, e.carry});
          checkOutput("ovf", {31'b0, out_ovf}, {31'b0, e.ovf});
        end
      end
      if (out_valid === 1'b1 && !out_ready) begin
        checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
        if (prev_stall) checkOutput("stall_hold", {16'b0, out_sum}, {16'b0, prev_sum});
        prev_stall = 1;
        prev_sum   = out_sum;
      end else begin
        prev_stall = 0;
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  initial begin
    int   t;
    int   total;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;

    // Reset held with a valid beat presented
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 16'h1234;
    in_b      = 16'h0FFF;
    in_carry  = 1'b0;
    out_ready = 1'b1;
    cur_exp   = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_out_sum", {16'b0, out_sum}, 32'd0);
    checkOutput("rst_out_carry", {31'b0, out_carry}, 32'd0);
    checkOutput("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

    // Single beat latency and result
    measureLatency(0, "latency");
    drain("drain_latency");

    // Directed vectors back-to-back: carry chains, wrap-around, overflow
    for (int i = 1; i < 10; i++) sendVec(i);
    drain("drain_directed");

    // Back-pressure: out_ready low for 5 cycles while 8 beats stream
    stall_lo = cyc + 5;
    stall_hi = cyc + 10;
    for (int i = 0; i < 8; i++) sendVec(i);
    drain("drain_backpressure");
    stall_lo = -1;
    stall_hi = -1;
    out_ready = 1'b1;

    // Full-rate random stream: every beat accepted on first try
    total = 0;
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      applyStimulus(1'b1, ra, rb, rc, refModel(ra, rb, rc), t);
      total += t;
    end
    checkOutput("throughput", total, 32'd100);
    drain("drain_random");

    // Reset with three beats in flight: none may ever emerge
    sendVec(7);
    sendVec(8);
    sendVec(9);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;
    measureLatency(4, "latency_after_rst");
    drain("drain_after_rst");
    idle(6);
    checkOutput("final_queue", exp_q.size(), 32'd0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
